uart_tx_queue: RTL and testbench

Byte FIFO and handshake controller that sits directly upstream of the 115 200 Bd UART transmitter. It accepts bytes from any producer over a valid/ready stream and drives the UART's data/send/busy handshake, so producers can burst bytes without tracking transmitter timing. Bytes reach the UART in strict arrival order.

---
 rtl/uart_tx_queue.sv | 90 +++++++++
 tb/tb_uart_tx_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding the UART transmitter's data/send/busy handshake.
// Define UART_TX_QUEUE_TIMEOUT_EN to build in the send-acknowledge timeout.
module uart_tx_queue #(
    parameter int DEPTH_LOG2     = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  ipClk,
    input  logic                  reset,
    input  logic [7:0]            ipData,
    input  logic                  ipValid,
    output logic                  opReady,
    output logic [7:0]            opTxData,
    output logic                  opTxSend,
    input  logic                  ipTxBusy,
    output logic [DEPTH_LOG2:0]   opCount,
    output logic                  opEmpty,
    output logic                  opFull,
    output logic                  opTimeout
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8 || TIMEOUT_CYCLES < 2) begin : badParams
        $error("uart_tx_queue: illegal DEPTH_LOG2 or TIMEOUT_CYCLES");
    end

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
    logic [0:0]            state;
    logic                  push, pop, toHit;

    assign opFull  = opCount == {1'b1, {DEPTH_LOG2{1'b0}}};
    assign opEmpty = opCount == '0;
    assign opReady = !opFull;
    assign push    = ipValid && opReady;
    // A byte leaves the FIFO only once the UART has acknowledged it
    assign pop     = state == SEND && ipTxBusy;

    always_ff @(posedge ipClk) begin
        if (push) mem[wrPtr] <= ipData;
    end

    always_ff @(posedge ipClk) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            opCount  <= '0;
            state    <= IDLE;
            opTxSend <= 1'b0;
            opTxData <= 8'h00;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            opCount <= opCount + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
            if (state == IDLE) begin
                if (!opEmpty && !ipTxBusy) begin
                    opTxData <= mem[rdPtr];
                    opTxSend <= 1'b1;
                    state    <= SEND;
                end
            end else if (ipTxBusy || toHit) begin
                opTxSend <= 1'b0;
                state    <= IDLE;
            end
        end
    end

`ifdef UART_TX_QUEUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] toCnt;

    // Counter sits at zero in IDLE, so it is already clear on entry to SEND
    assign toHit = state == SEND && !ipTxBusy && toCnt == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge ipClk) begin
        if (reset) begin
            toCnt     <= '0;
            opTimeout <= 1'b0;
        end else begin
            toCnt <= (state == SEND) ? toCnt + 1'b1 : '0;
            if (toHit) opTimeout <= 1'b1;
        end
    end
`else
    assign toHit     = 1'b0;
    assign opTimeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed scoreboard bench for uart_tx_queue with a handshake-level UART model.
// Covers the UART_TX_QUEUE_TIMEOUT_EN build when that macro is defined.
module tb_uart_tx_queue;
    localparam int DEPTH = 16;

    logic       ipClk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ipData = 8'h00;
    logic       ipValid = 1'b0;
    logic       ipTxBusy = 1'b0;
    logic       opReady, opTxSend, opEmpty, opFull, opTimeout;
    logic [7:0] opTxData;
    logic [4:0] opCount;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];

    uart_tx_queue #(.DEPTH_LOG2(4), .TIMEOUT_CYCLES(100)) dut (
        .ipClk(ipClk), .reset(reset), .ipData(ipData), .ipValid(ipValid),
        .opReady(opReady), .opTxData(opTxData), .opTxSend(opTxSend), .ipTxBusy(ipTxBusy),
        .opCount(opCount), .opEmpty(opEmpty), .opFull(opFull), .opTimeout(opTimeout)
    );

    always #5 ipClk = ~ipClk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge ipClk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        ipData  = b;
        ipValid = 1'b1;
        tick();
        ipValid = 1'b0;
        if (q.size() < DEPTH) q.push_back(b);
    endtask

    task automatic waitSend();
        int t = 0;
        while (!opTxSend && t < 1000) begin
            tick();
            t++;
        end
        chk("send_rise", opTxSend, 1);
    endtask

    task automatic serve(input int n, input int dwell);
        for (int i = 0; i < n; i++) begin
            waitSend();
            chk("tx_data", opTxData, q.size() > 0 ? q[0] : 8'hxx);
            repeat (dwell) tick();
            ipTxBusy = 1'b1;
            tick();
            if (q.size() > 0) void'(q.pop_front());
            chk("send_fall", opTxSend, 0);
            chk("count_after_pop", opCount, q.size());
            repeat (2) tick();
            ipTxBusy = 1'b0;
            tick();
        end
    endtask

    initial begin
        logic held;
        int n;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_count", opCount, 0);
        chk("rst_empty", opEmpty, 1);
        chk("rst_full", opFull, 0);
        chk("rst_ready", opReady, 1);
        chk("rst_send", opTxSend, 0);
        chk("rst_data", opTxData, 8'h00);
        chk("rst_timeout", opTimeout, 0);

        push(8'hA5);
        chk("single_not_early", opTxSend, 0);
        chk("single_count", opCount, 1);
        tick();
        chk("single_send", opTxSend, 1);
        chk("single_data", opTxData, 8'hA5);
        held = 1'b1;
        repeat (434) begin
            tick();
            if (!opTxSend) held = 1'b0;
        end
        chk("single_dwell", held, 1);
        ipTxBusy = 1'b1;
        tick();
        void'(q.pop_front());
        chk("single_fall", opTxSend, 0);
        chk("single_count0", opCount, 0);
        repeat (2) tick();
        ipTxBusy = 1'b0;
        tick();

        ipTxBusy = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            push(8'(i));
            if (i == 15) begin
                chk("fill_full", opFull, 1);
                chk("fill_ready", opReady, 0);
            end
        end
        chk("fill_count", opCount, 16);
        chk("fill_send_idle", opTxSend, 0);
        ipTxBusy = 1'b0;
        serve(16, 3);
        chk("fill_empty", opEmpty, 1);
        chk("fill_sb_empty", q.size(), 0);

        for (int i = 0; i < 11; i++) push(8'h40 + 8'(i));
        serve(11, 0);
        ipTxBusy = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        chk("wrap_count", opCount, 5);
        ipTxBusy = 1'b0;
        waitSend();
        chk("wrap_head", opTxData, q[0]);
        ipTxBusy = 1'b1;
        ipData   = 8'h77;
        ipValid  = 1'b1;
        tick();
        ipValid = 1'b0;
        void'(q.pop_front());
        q.push_back(8'h77);
        chk("simul_count", opCount, 5);
        chk("simul_fall", opTxSend, 0);
        repeat (2) tick();
        ipTxBusy = 1'b0;
        serve(5, 1);
        chk("wrap_empty", opEmpty, 1);

        push(8'h3C);
        waitSend();
`ifdef UART_TX_QUEUE_TIMEOUT_EN
        n = 0;
        while (opTxSend && n < 300) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 100);
        chk("to_flag", opTimeout, 1);
        chk("to_no_pop", opCount, 1);
        serve(1, 3);
        chk("to_sticky", opTimeout, 1);
`else
        n = 0;
        held = 1'b1;
        repeat (300) begin
            tick();
            if (!opTxSend) held = 1'b0;
        end
        chk("no_to_held", held, 1);
        chk("no_to_flag", opTimeout, 0);
        serve(1, 0);
`endif

        ipTxBusy = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i));
        ipTxBusy = 1'b0;
        waitSend();
        reset = 1'b1;
        tick();
        chk("rst_mid_send", opTxSend, 0);
        chk("rst_mid_count", opCount, 0);
        reset = 1'b0;
        q.delete();
        held = 1'b0;
        repeat (50) begin
            tick();
            if (opTxSend) held = 1'b1;
        end
        chk("rst_no_resend", held, 0);
        chk("rst_mid_empty", opEmpty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
